// File: rtl/cardinal_nic.sv
// cardinal_nic: single-buffered processor/ring-router network interface with polarity-gated injection
module cardinal_nic #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);
    logic [DATA_WIDTH-1:0] in_buf, out_buf, rd_data;
    logic in_full, out_full, ovf, rd, wr_out;
    assign rd = nicEn & ~nicWrEn;
    assign wr_out = nicEn & nicWrEn & (addr == 2'b10);
    assign net_ri = ~in_full & ~rst;
    assign net_so = out_full & net_ro & (out_buf[DATA_WIDTH-1] == net_polarity) & ~rst;
    assign net_do = out_buf;
    always_comb begin
        rd_data = addr == 2'b00 ? in_buf :
                  addr == 2'b01 ? {{(DATA_WIDTH-1){1'b0}}, in_full} :
                  addr == 2'b10 ? out_buf :
                                  {{(DATA_WIDTH-2){1'b0}}, ovf, out_full};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            in_buf   <= '0;
            out_buf  <= '0;
            in_full  <= 1'b0;
            out_full <= 1'b0;
            ovf      <= 1'b0;
            d_out    <= '0;
        end else begin
            if (rd)
                d_out <= rd_data;
            if (net_si && net_ri) begin
                in_buf  <= net_di;
                in_full <= 1'b1;
            end else if (rd && addr == 2'b00)
                in_full <= 1'b0;
            if (wr_out && !out_full)
                out_buf <= d_in;
            out_full <= net_so ? 1'b0 : (wr_out | out_full);
            ovf <= (wr_out & out_full) | (ovf & ~(rd && addr == 2'b11));
        end
    end
endmodule

// File: tb/tb_cardinal_nic.sv
// tb_cardinal_nic: directed and random checks of cardinal_nic against a register-file/handshake reference model
module tb_cardinal_nic;
    logic clk = 1'b0, rst = 1'b1, nicEn = 1'b0, nicWrEn = 1'b0;
    logic net_si = 1'b0, net_ro = 1'b0, net_polarity = 1'b0;
    logic [1:0] addr = 2'b00;
    logic [63:0] d_in = '0, net_di = '0;
    logic [63:0] d_out, net_do;
    logic net_ri, net_so;
    int total = 0, bad = 0;
    logic [63:0] m_in_val = '0, m_out_val = '0, m_dout = '0;
    bit m_in_full = 0, m_out_full = 0, m_ovf = 0;

    cardinal_nic dut (
        .clk(clk), .rst(rst), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        bit e_ri, e_so;
        logic [63:0] n_in_val, n_out_val;
        bit n_in_full, n_out_full, n_ovf;
        #1;
        e_ri = !m_in_full && !rst;
        e_so = m_out_full && net_ro && (m_out_val[63] == net_polarity) && !rst;
        chk("net_ri", net_ri, e_ri);
        chk("net_so", net_so, e_so);
        chk("net_do", net_do, m_out_val);
        n_in_val = m_in_val; n_out_val = m_out_val;
        n_in_full = m_in_full; n_out_full = m_out_full; n_ovf = m_ovf;
        if (rst) begin
            n_in_val = '0; n_out_val = '0; m_dout = '0;
            n_in_full = 0; n_out_full = 0; n_ovf = 0;
        end else begin
            if (nicEn && !nicWrEn) begin
                case (addr)
                    2'b00: begin m_dout = m_in_val; n_in_full = 0; end
                    2'b01: m_dout = {63'b0, m_in_full};
                    2'b10: m_dout = m_out_val;
                    default: begin m_dout = {62'b0, m_ovf, m_out_full}; n_ovf = 0; end
                endcase
            end
            if (net_si && e_ri) begin n_in_val = net_di; n_in_full = 1; end
            if (nicEn && nicWrEn && addr == 2'b10) begin
                if (m_out_full) n_ovf = 1;
                else begin n_out_val = d_in; n_out_full = 1; end
            end
            if (e_so) n_out_full = 0;
        end
        m_in_val = n_in_val; m_out_val = n_out_val;
        m_in_full = n_in_full; m_out_full = n_out_full; m_ovf = n_ovf;
        @(posedge clk);
        #1;
        chk("d_out", d_out, m_dout);
    endtask

    task automatic rd(input logic [1:0] a);
        nicEn = 1; nicWrEn = 0; addr = a;
        cyc();
        nicEn = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1; nicWrEn = 1; addr = a; d_in = d;
        cyc();
        nicEn = 0; nicWrEn = 0;
    endtask

    initial begin
        int sends, wrong;
        logic [63:0] held;
        @(posedge clk);
        #1;
        net_si = 1; net_ro = 1; net_di = 64'hDEAD_BEEF_0000_0001;
        cyc();
        cyc();
        chk("rst_dout", d_out, 64'h0);
        rst = 0; net_si = 0; net_ro = 0;
        #1;
        chk("rel_ri", net_ri, 1'b1);
        rd(2'b01); chk("rel_st01", d_out, 64'h0);
        rd(2'b11); chk("rel_st11", d_out, 64'h0);

        net_si = 1; net_di = 64'h0000_00FF_1234_5678;
        cyc();
        net_si = 0;
        #1;
        chk("ej_ri", net_ri, 1'b0);
        rd(2'b01); chk("ej_st01", d_out, 64'h1);
        rd(2'b00); chk("ej_data", d_out, 64'h0000_00FF_1234_5678);
        rd(2'b01); chk("ej_st01_clr", d_out, 64'h0);
        chk("ej_ri_back", net_ri, 1'b1);

        net_ro = 1; net_polarity = 0;
        wr(2'b10, 64'h8000_0000_0000_00AA);
        sends = 0; wrong = 0;
        for (int i = 0; i < 4; i++) begin
            net_polarity = i[0];
            #1;
            if (net_so) sends++;
            if (net_so && !net_polarity) wrong++;
            cyc();
        end
        chk("pol_sends", sends, 1);
        chk("pol_wrong", wrong, 0);
        rd(2'b11); chk("pol_st11", d_out, 64'h0);

        net_ro = 0;
        wr(2'b10, 64'h0123_4567_89AB_CDEF);
        held = net_do;
        for (int i = 0; i < 5; i++) begin
            net_polarity = i[0];
            cyc();
        end
        chk("bp_do", net_do, held);
        net_ro = 1; net_polarity = 0;
        #1;
        chk("bp_so", net_so, 1'b1);
        cyc();
        chk("bp_so_once", net_so, 1'b0);

        net_ro = 0;
        wr(2'b10, 64'h0000_0000_0000_0011);
        wr(2'b10, 64'h0000_0000_0000_0022);
        rd(2'b10); chk("ovf_keep", d_out, 64'h11);
        rd(2'b11); chk("ovf_st11", d_out, 64'h3);
        rd(2'b11); chk("ovf_st11_clr", d_out, 64'h1);
        net_ro = 1;
        for (int i = 0; i < 2; i++) begin
            net_polarity = i[0];
            cyc();
        end

        net_ro = 0; net_si = 1; net_di = 64'h4444_0000_0000_0044;
        wr(2'b10, 64'h0000_0000_0000_0055);
        net_si = 0; net_ro = 1; net_polarity = 0;
        rst = 1;
        cyc();
        rst = 0;
        #1;
        chk("mr_ri", net_ri, 1'b1);
        chk("mr_so", net_so, 1'b0);
        rd(2'b01); chk("mr_st01", d_out, 64'h0);
        rd(2'b11); chk("mr_st11", d_out, 64'h0);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            nicEn = $urandom_range(0, 1);
            nicWrEn = $urandom_range(0, 1);
            addr = 2'($urandom_range(0, 3));
            d_in = {$urandom, $urandom};
            net_si = $urandom_range(0, 1);
            net_di = {$urandom, $urandom};
            net_ro = ($urandom_range(0, 3) != 0);
            net_polarity = $urandom_range(0, 1);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
